// File: rtl/joy_serial_pkg.sv
// Shared definitions for the joystick serial transmitter: FSM state encoding,
// button bit positions within one player's byte, and the default chain length.
package joy_serial_pkg;

    localparam int CHAIN_LEN_DEF = 16;

    // Bit positions inside an 8-bit active-low player vector
    localparam int BTN_START = 7;
    localparam int BTN_FIRE3 = 6;
    localparam int BTN_FIRE2 = 5;
    localparam int BTN_FIRE1 = 4;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_UP    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } joy_state_t;

endpackage

// File: rtl/joy_debounce.sv
// Multi-bit button debouncer. One shared down-counter produces a sample tick
// every DIV cycles; each line's output follows its input only after three
// consecutive equal samples. Built only when JOY_DEBOUNCE_EN is defined.
module joy_debounce #(
    parameter int WIDTH = 16,
    parameter int DIV   = 50000
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int            TW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_RELOAD = TW'(DIV - 1);

    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic [WIDTH-1:0] smp0_q, smp0_d;
    logic [WIDTH-1:0] smp1_q, smp1_d;
    logic [WIDTH-1:0] smp2_q, smp2_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] stable;

    // Tick generation, sample history shift and per-line stability update
    always_comb begin
        tick       = (tick_cnt_q == '0);
        tick_cnt_d = tick ? TICK_RELOAD : tick_cnt_q - TW'(1);
        smp0_d     = smp0_q;
        smp1_d     = smp1_q;
        smp2_d     = smp2_q;
        if (tick) begin
            smp0_d = din;
            smp1_d = smp0_q;
            smp2_d = smp1_q;
        end
        stable = ~(smp0_q ^ smp1_q) & ~(smp1_q ^ smp2_q);
        out_d  = (out_q & ~stable) | (smp0_q & stable);
    end

    // Debounce state registers; released buttons (all 1s) out of reset
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= TICK_RELOAD;
            smp0_q     <= '1;
            smp1_q     <= '1;
            smp2_q     <= '1;
            out_q      <= '1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            smp0_q     <= smp0_d;
            smp1_q     <= smp1_d;
            smp2_q     <= smp2_d;
            out_q      <= out_d;
        end
    end

    assign dout = out_q;

endmodule

// File: rtl/joy_serial_tx.sv
// Controller-side joystick serial chain transmitter. Latches {joy1_n, joy2_n}
// while JOY_LOAD is low and shifts one bit per JOY_CLK rising edge, MSB first.
// JOY_CLK, JOY_LOAD and the buttons are sampled as data on clk_sys.
// Optional macro JOY_DEBOUNCE_EN: frames load debounced buttons (joy_debounce)
// instead of the plain synchronised ones, and adds the DEBOUNCE_DIV parameter.
//
// state | meaning
// IDLE  | no frame latched since reset, joy_data held at 1
// LOAD  | load strobe low, shift reg follows buttons, joy_data = item 0
// SHIFT | frame frozen, each JOY_CLK rise presents the next item
// DONE  | all items sent, joy_data held at 1 until the next load
module joy_serial_tx
    import joy_serial_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF
`ifdef JOY_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_DIV = 50000
`endif
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       joy_clk,
    input  logic       joy_load,
    input  logic [7:0] joy1_n,
    input  logic [7:0] joy2_n,
    output logic       joy_data,
    output logic       frame_done
);

    localparam int               CNT_W    = $clog2(CHAIN_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

    logic [1:0]           clk_sync_q, clk_sync_d;
    logic                 clk_prev_q, clk_prev_d;
    logic [1:0]           load_sync_q, load_sync_d;
    logic [15:0]          btn_meta_q, btn_meta_d;
    logic [15:0]          btn_sync_q, btn_sync_d;
    logic                 clk_rise;
    logic                 load_s;
    logic [15:0]          frame_vec;

    joy_state_t           state_q, state_d;
    logic [CHAIN_LEN-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 joy_data_q, joy_data_d;
    logic                 frame_done_q, frame_done_d;

`ifdef JOY_DEBOUNCE_EN
    joy_debounce #(
        .WIDTH (16),
        .DIV   (DEBOUNCE_DIV)
    ) u_debounce (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .din     (btn_sync_q),
        .dout    (frame_vec)
    );
`else
    assign frame_vec = btn_sync_q;
`endif

    // Two-flop synchronisers for all host/button inputs plus JOY_CLK history
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], joy_clk};
        clk_prev_d  = clk_sync_q[1];
        load_sync_d = {load_sync_q[0], joy_load};
        btn_meta_d  = {joy1_n, joy2_n};
        btn_sync_d  = btn_meta_q;
    end

    assign clk_rise = clk_sync_q[1] & ~clk_prev_q;
    assign load_s   = load_sync_q[1];

    // Next-state, shift register, bit counter and registered outputs
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
        if (!load_s) begin
            // Load wins over everything, including a coincident clock edge
            state_d                      = LOAD;
            shift_d                      = '1;
            shift_d[CHAIN_LEN-1 -: 16]   = frame_vec;
            bit_cnt_d                    = '0;
        end else begin
            case (state_q)
                IDLE: ;
                LOAD: state_d = SHIFT;
                SHIFT: begin
                    if (clk_rise) begin
                        shift_d = {shift_q[CHAIN_LEN-2:0], 1'b1};
                        if (bit_cnt_q == CNT_LAST) begin
                            state_d      = DONE;
                            bit_cnt_d    = CNT_FULL;
                            frame_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
        joy_data_d = ((state_d == LOAD) || (state_d == SHIFT)) ? shift_d[CHAIN_LEN-1] : 1'b1;
    end

    // All state registers; reset returns the chain to idle-high
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q   <= 2'b11;
            clk_prev_q   <= 1'b1;
            load_sync_q  <= 2'b11;
            btn_meta_q   <= '1;
            btn_sync_q   <= '1;
            state_q      <= IDLE;
            shift_q      <= '1;
            bit_cnt_q    <= '0;
            joy_data_q   <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            clk_prev_q   <= clk_prev_d;
            load_sync_q  <= load_sync_d;
            btn_meta_q   <= btn_meta_d;
            btn_sync_q   <= btn_sync_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            joy_data_q   <= joy_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign joy_data   = joy_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_joy_serial_tx.sv
// Directed bench for joy_serial_tx acting as the host: JOY_CLK idles high,
// each period is a low half then a high half, and joy_data is sampled at the
// falling edge. Define JOY_DEBOUNCE_EN to also exercise the debouncer.
module tb_joy_serial_tx;
    import joy_serial_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       joy_clk;
    logic       joy_load;
    logic [7:0] joy1_n;
    logic [7:0] joy2_n;
    logic       joy_data;
    logic       frame_done;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    // Counts frame_done pulses, one count per high cycle
    always @(negedge clk_sys) if (frame_done === 1'b1) fd_cnt++;

`ifdef JOY_DEBOUNCE_EN
    joy_serial_tx #(.CHAIN_LEN(16), .DEBOUNCE_DIV(4)) dut (
`else
    joy_serial_tx #(.CHAIN_LEN(16)) dut (
`endif
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy1_n     (joy1_n),
        .joy2_n     (joy2_n),
        .joy_data   (joy_data),
        .frame_done (frame_done)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic set_buttons(input logic [7:0] p1, input logic [7:0] p2);
        joy1_n = p1;
        joy2_n = p2;
        wait_clk(40);
    endtask

    task automatic send_load();
        joy_load = 1'b0;
        wait_clk(16);
        joy_load = 1'b1;
        wait_clk(8);
    endtask

    // One host JOY_CLK period: sample at the falling edge, then rise
    task automatic clk_pulse(output logic s);
        s       = joy_data;
        joy_clk = 1'b0;
        wait_clk(8);
        joy_clk = 1'b1;
        wait_clk(8);
    endtask

    task automatic test_reset();
        logic s;
        int   f0;
        reset_n  = 1'b0;
        joy_clk  = 1'b1;
        joy_load = 1'b1;
        joy1_n   = 8'hFF;
        joy2_n   = 8'hFF;
        wait_clk(3);
        checks++; if (joy_data !== 1'b1) begin errors++; $display("FAIL reset_joy_data: got %b expected 1", joy_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
        reset_n = 1'b1;
        wait_clk(5);
        for (int i = 0; i < 3; i++) begin
            clk_pulse(s);
            checks++; if (s !== 1'b1) begin errors++; $display("FAIL idle_no_load bit%0d: got %b expected 1", i, s); end
        end
        // Reset in the middle of a frame of zeros
        set_buttons(8'h00, 8'h00);
        send_load();
        for (int i = 0; i < 3; i++) begin
            clk_pulse(s);
            checks++; if (s !== 1'b0) begin errors++; $display("FAIL pre_reset_bit%0d: got %b expected 0", i, s); end
        end
        checks++; if (dut.state_q !== SHIFT) begin errors++; $display("FAIL pre_reset_state: got %0d expected %0d", dut.state_q, SHIFT); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (joy_data !== 1'b1) begin errors++; $display("FAIL midreset_joy_data: got %b expected 1", joy_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midreset_frame_done: got %b expected 0", frame_done); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL midreset_state: got %0d expected %0d", dut.state_q, IDLE); end
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(4);
        f0 = fd_cnt;
        for (int i = 0; i < 2; i++) begin
            clk_pulse(s);
            checks++; if (s !== 1'b1) begin errors++; $display("FAIL post_reset_bit%0d: got %b expected 1", i, s); end
        end
        checks++; if (fd_cnt - f0 !== 0) begin errors++; $display("FAIL post_reset_frame_done: got %0d pulses expected 0", fd_cnt - f0); end
    endtask

    task automatic test_frame();
        logic        s;
        int          f0;
        logic [15:0] exp_bits;
        exp_bits = 16'b1110_1111_1111_1110;
        set_buttons(8'hEF, 8'hFE);
        f0 = fd_cnt;
        send_load();
        for (int i = 0; i < 16; i++) begin
            clk_pulse(s);
            checks++; if (s !== exp_bits[15-i]) begin errors++; $display("FAIL frame item%0d: got %b expected %b", i, s, exp_bits[15-i]); end
        end
        wait_clk(4);
        checks++; if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", fd_cnt - f0); end
        checks++; if (dut.state_q !== DONE) begin errors++; $display("FAIL frame_state: got %0d expected %0d", dut.state_q, DONE); end
    endtask

    task automatic test_latency();
        logic s;
        // joy1 = 0110_1111: items 0..4 = 0,1,1,0,1
        set_buttons(8'h6F, 8'hFF);
        joy_load = 1'b0;
        wait_clk(2);
        checks++; if (joy_data !== 1'b1) begin errors++; $display("FAIL load_latency_early: got %b expected 1", joy_data); end
        wait_clk(1);
        checks++; if (joy_data !== 1'b0) begin errors++; $display("FAIL load_latency_3cyc: got %b expected 0", joy_data); end
        wait_clk(13);
        joy_load = 1'b1;
        wait_clk(8);
        for (int i = 0; i < 3; i++) clk_pulse(s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL latency_item2: got %b expected 1", s); end
        joy_clk = 1'b0;
        wait_clk(8);
        joy_clk = 1'b1;
        wait_clk(2);
        checks++; if (joy_data !== 1'b0) begin errors++; $display("FAIL clk_latency_early: got %b expected 0", joy_data); end
        wait_clk(1);
        checks++; if (joy_data !== 1'b1) begin errors++; $display("FAIL clk_latency_3cyc: got %b expected 1", joy_data); end
        wait_clk(5);
    endtask

    task automatic test_overrun();
        logic s;
        int   f0;
        set_buttons(8'hEF, 8'hFE);
        f0 = fd_cnt;
        send_load();
        for (int i = 0; i < 20; i++) begin
            clk_pulse(s);
            if (i == 3) begin
                checks++; if (s !== 1'b0) begin errors++; $display("FAIL overrun item3: got %b expected 0", s); end
            end
            if (i >= 16) begin
                checks++; if (s !== 1'b1) begin errors++; $display("FAIL overrun bit%0d: got %b expected 1", i + 1, s); end
            end
        end
        wait_clk(4);
        checks++; if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL overrun_frame_done: got %0d expected 1", fd_cnt - f0); end
        checks++; if (dut.bit_cnt_q !== 5'd16) begin errors++; $display("FAIL overrun_bit_cnt: got %0d expected 16", dut.bit_cnt_q); end
    endtask

    task automatic test_abort();
        logic       s;
        int         f0;
        logic [4:0] exp_a;
        exp_a = 5'b11101;
        set_buttons(8'hEF, 8'hFE);
        f0 = fd_cnt;
        send_load();
        for (int i = 0; i < 5; i++) begin
            clk_pulse(s);
            checks++; if (s !== exp_a[4-i]) begin errors++; $display("FAIL abort_first item%0d: got %b expected %b", i, s, exp_a[4-i]); end
        end
        set_buttons(8'h7F, 8'hFE);
        send_load();
        clk_pulse(s);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL abort_restart item0: got %b expected 0", s); end
        clk_pulse(s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL abort_restart item1: got %b expected 1", s); end
        checks++; if (fd_cnt - f0 !== 0) begin errors++; $display("FAIL abort_frame_done: got %0d expected 0", fd_cnt - f0); end
    endtask

    task automatic test_freeze();
        logic s;
        int   f0;
        set_buttons(8'hFF, 8'hFF);
        f0 = fd_cnt;
        send_load();
        clk_pulse(s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL freeze item0: got %b expected 1", s); end
        joy1_n = 8'h00;
        for (int i = 1; i < 16; i++) begin
            clk_pulse(s);
            checks++; if (s !== 1'b1) begin errors++; $display("FAIL freeze item%0d: got %b expected 1", i, s); end
        end
        wait_clk(40);
        send_load();
        for (int i = 0; i < 16; i++) begin
            clk_pulse(s);
            checks++; if (s !== (i >= 8)) begin errors++; $display("FAIL next_frame item%0d: got %b expected %b", i, s, (i >= 8)); end
        end
        wait_clk(4);
        checks++; if (fd_cnt - f0 !== 2) begin errors++; $display("FAIL freeze_frame_done: got %0d expected 2", fd_cnt - f0); end
    endtask

`ifdef JOY_DEBOUNCE_EN
    task automatic test_debounce();
        logic s;
        set_buttons(8'hFF, 8'hFF);
        joy2_n[4] = 1'b0;
        wait_clk(8);
        joy2_n[4] = 1'b1;
        wait_clk(40);
        send_load();
        for (int i = 0; i < 16; i++) begin
            clk_pulse(s);
            checks++; if (s !== 1'b1) begin errors++; $display("FAIL glitch item%0d: got %b expected 1", i, s); end
        end
        joy2_n[4] = 1'b0;
        wait_clk(24);
        send_load();
        for (int i = 0; i < 16; i++) begin
            clk_pulse(s);
            checks++; if (s !== (i != 11)) begin errors++; $display("FAIL press item%0d: got %b expected %b", i, s, (i != 11)); end
        end
        joy2_n[4] = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_latency();
        test_overrun();
        test_abort();
        test_freeze();
`ifdef JOY_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
